// File: rtl/fetch_decode_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue_pkg
//   Shared front-end defines for the fetch -> decode path.
//   Contents:
//     IQ_DEPTH    default instruction-queue depth (power of two, >= 4)
//     IQ_PTR_W    pointer width for the default depth
//     InstBundle  one fetched instruction with its branch prediction
//     UOPBundle   decoded micro-op handed from decode to rename
//     inst_valid_count  number of valid instructions in a fetch pair
// -----------------------------------------------------------------------------
package fetch_decode_queue_pkg;

   localparam int IQ_DEPTH = 8;
   localparam int IQ_PTR_W = $clog2(IQ_DEPTH);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        predTaken;
      logic [31:0] predAddr;
   } InstBundle;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [7:0]  opcode;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        predTaken;
      logic [31:0] predAddr;
   } UOPBundle;

   // Number of instructions carried by a fetch pair (0, 1 or 2).
   function automatic logic [1:0] inst_valid_count(input logic v0, input logic v1);
      return {1'b0, v0} + {1'b0, v1};
   endfunction

endpackage

// File: rtl/Ctrl.sv
// -----------------------------------------------------------------------------
// Ctrl
//   Pipeline control bundle shared by the front-end stages.
//   Signals:
//     pause     hold the stage's outputs (driven by the pipeline controller)
//     flush     discard all in-flight state (driven by the pipeline controller)
//     pauseReq  stage asks the controller to stall upstream
//   Modports:
//     slave   stage side  (pause/flush in, pauseReq out)
//     master  controller side
// -----------------------------------------------------------------------------
interface Ctrl;
   logic pause;
   logic flush;
   logic pauseReq;

   modport slave  (input pause, input flush, output pauseReq);
   modport master (output pause, output flush, input pauseReq);
endinterface

// File: rtl/fetch_decode_queue_ram.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue_ram
//   DEPTH x InstBundle storage for the instruction queue.
//   Two write ports (one per fetched instruction) and two asynchronous read
//   ports (one per decoder). The consumer registers the read data, so the
//   read-to-decoder path still ends in a flop.
//   Ports:
//     clk              clock
//     we0/waddr0/wdata0  write port 0
//     we1/waddr1/wdata1  write port 1 (never the same address as port 0)
//     raddr0/rdata0    read port 0
//     raddr1/rdata1    read port 1
//   The array carries no reset: every read is qualified by the queue count.
// -----------------------------------------------------------------------------
module fetch_decode_queue_ram
   import fetch_decode_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we0,
   input  logic [PTR_W-1:0] waddr0,
   input  InstBundle        wdata0,
   input  logic             we1,
   input  logic [PTR_W-1:0] waddr1,
   input  InstBundle        wdata1,
   input  logic [PTR_W-1:0] raddr0,
   output InstBundle        rdata0,
   input  logic [PTR_W-1:0] raddr1,
   output InstBundle        rdata1
);

   InstBundle mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we0) begin
         mem[waddr0] <= wdata0;
      end
      if (we1) begin
         mem[waddr1] <= wdata1;
      end
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//   Circular instruction queue between a 2-wide fetch stage and two decoders.
//   Accepts up to two instructions per cycle (compacted, program order) when
//   at least two slots are free, and hands up to two instructions per cycle
//   to the decoders through registered outputs.
//   Ports:
//     clk                      clock, all state updates on the rising edge
//     rst                      synchronous reset, active low
//     ctrl_fetch_decode_queue  pause / flush in, pauseReq out (tied low)
//     fetch_inst0              older fetched instruction
//     fetch_inst1              younger fetched instruction
//     fetch_ready              queue can take two instructions this cycle
//     decode0_inst             instruction for decoder 0 (older)
//     decode1_inst             instruction for decoder 1 (younger)
// -----------------------------------------------------------------------------
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) (
   input  logic      clk,
   input  logic      rst,
   Ctrl.slave        ctrl_fetch_decode_queue,
   input  InstBundle fetch_inst0,
   input  InstBundle fetch_inst1,
   output logic      fetch_ready,
   output InstBundle decode0_inst,
   output InstBundle decode1_inst
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W:0]   count_reg, count_next;
   InstBundle        decode0_reg, decode0_next;
   InstBundle        decode1_reg, decode1_next;

   logic             pause;
   logic             flush;
   logic             push_ok;
   logic             push0, push1;
   logic [PTR_W:0]   push_cnt;
   logic [PTR_W:0]   pop_cnt;
   logic [PTR_W-1:0] waddr1;
   logic [PTR_W-1:0] raddr1;
   InstBundle        rdata0, rdata1;

   assign pause = ctrl_fetch_decode_queue.pause;
   assign flush = ctrl_fetch_decode_queue.flush;

   // Only registered count feeds fetch_ready, so fetch sees a clean flop path.
   assign fetch_ready = (count_reg <= (PTR_W+1)'(DEPTH - 2));

   // Back-pressure is carried entirely by fetch_ready.
   assign ctrl_fetch_decode_queue.pauseReq = 1'b0;

   // Anything presented during flush or reset is dropped, not stored.
   assign push_ok  = fetch_ready && !flush && rst;
   assign push0    = push_ok && fetch_inst0.valid;
   assign push1    = push_ok && fetch_inst1.valid;
   assign push_cnt = (PTR_W+1)'(inst_valid_count(push0, push1));

   // Compaction: inst1 lands directly behind inst0 if that was written,
   // otherwise at the write pointer itself.
   assign waddr1 = wr_ptr_reg + PTR_W'(push0);
   assign raddr1 = rd_ptr_reg + PTR_W'(1);

   fetch_decode_queue_ram #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_ram (
      .clk    (clk),
      .we0    (push0),
      .waddr0 (wr_ptr_reg),
      .wdata0 (fetch_inst0),
      .we1    (push1),
      .waddr1 (waddr1),
      .wdata1 (fetch_inst1),
      .raddr0 (rd_ptr_reg),
      .rdata0 (rdata0),
      .raddr1 (raddr1),
      .rdata1 (rdata1)
   );

   always_comb begin
      pop_cnt      = '0;
      rd_ptr_next  = rd_ptr_reg;
      wr_ptr_next  = wr_ptr_reg + push_cnt[PTR_W-1:0];
      count_next   = count_reg;
      decode0_next = decode0_reg;
      decode1_next = decode1_reg;

      if (!pause) begin
         // Drain up to two entries; missing slots go out all-zero so decode1
         // can never be valid while decode0 is not.
         if (count_reg >= (PTR_W+1)'(2)) begin
            pop_cnt = (PTR_W+1)'(2);
         end else begin
            pop_cnt = count_reg;
         end
         decode0_next = (count_reg >= (PTR_W+1)'(1)) ? rdata0 : '0;
         decode1_next = (count_reg >= (PTR_W+1)'(2)) ? rdata1 : '0;
      end

      rd_ptr_next = rd_ptr_reg + pop_cnt[PTR_W-1:0];
      // Push needs two free slots measured before the pop, so this cannot
      // exceed DEPTH.
      count_next  = count_reg + push_cnt - pop_cnt;

      if (flush) begin
         rd_ptr_next  = '0;
         wr_ptr_next  = '0;
         count_next   = '0;
         decode0_next = '0;
         decode1_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_reg  <= '0;
         wr_ptr_reg  <= '0;
         count_reg   <= '0;
         decode0_reg <= '0;
         decode1_reg <= '0;
      end else begin
         rd_ptr_reg  <= rd_ptr_next;
         wr_ptr_reg  <= wr_ptr_next;
         count_reg   <= count_next;
         decode0_reg <= decode0_next;
         decode1_reg <= decode1_next;
      end
   end

   assign decode0_inst = decode0_reg;
   assign decode1_inst = decode1_reg;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue (DEPTH 8).
module tb_fetch_decode_queue;
   import fetch_decode_queue_pkg::*;

   localparam int DEPTH = 8;

   logic      clk = 1'b0;
   logic      rst;
   InstBundle fetch_inst0, fetch_inst1;
   InstBundle decode0_inst, decode1_inst;
   logic      fetch_ready;

   Ctrl ctrl();

   always #5 clk = ~clk;

   fetch_decode_queue #(.DEPTH(DEPTH)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .ctrl_fetch_decode_queue (ctrl),
      .fetch_inst0             (fetch_inst0),
      .fetch_inst1             (fetch_inst1),
      .fetch_ready             (fetch_ready),
      .decode0_inst            (decode0_inst),
      .decode1_inst            (decode1_inst)
   );

   int        checks   = 0;
   int        failures = 0;
   InstBundle sb_q[$];          // accepted instructions not yet handed out
   InstBundle exp_d0 = '0;
   InstBundle exp_d1 = '0;
   bit        track_order = 1'b0;
   logic [31:0] next_out_pc = '0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic InstBundle mk(input bit v, input logic [31:0] pc);
      InstBundle b;
      b.valid     = v;
      b.pc        = pc;
      b.inst      = pc ^ 32'hA5A5_0000;
      b.predTaken = pc[3];
      b.predAddr  = pc + 32'h40;
      return b;
   endfunction

   task automatic drive(input bit v0, input logic [31:0] pc0, input bit v1, input logic [31:0] pc1,
                        input bit p, input bit f, input bit r);
      fetch_inst0 = mk(v0, pc0);
      fetch_inst1 = mk(v1, pc1);
      ctrl.pause  = p;
      ctrl.flush  = f;
      rst         = r;
   endtask

   // One clock: check ready, update the scoreboard at the edge, check outputs.
   task automatic step(input string tag, output bit accepted);
      bit exp_ready;
      bit p, f, r;
      exp_ready = (sb_q.size() <= DEPTH - 2);
      check({tag, "_ready"}, 128'(fetch_ready), 128'(exp_ready));
      @(posedge clk);
      p = ctrl.pause; f = ctrl.flush; r = rst;
      accepted = exp_ready && r && !f;
      if (!r || f) begin
         sb_q.delete();
         exp_d0 = '0;
         exp_d1 = '0;
      end else begin
         if (!p) begin
            exp_d0 = (sb_q.size() >= 1) ? sb_q.pop_front() : '0;
            exp_d1 = (sb_q.size() >= 1) ? sb_q.pop_front() : '0;
         end
         if (exp_ready) begin
            if (fetch_inst0.valid) sb_q.push_back(fetch_inst0);
            if (fetch_inst1.valid) sb_q.push_back(fetch_inst1);
         end
      end
      #1;
      check({tag, "_d0"}, 128'(decode0_inst), 128'(exp_d0));
      check({tag, "_d1"}, 128'(decode1_inst), 128'(exp_d1));
      check({tag, "_d1_without_d0"}, 128'(decode1_inst.valid & ~decode0_inst.valid), 128'(0));
      if (track_order && r && !f && !p) begin
         if (decode0_inst.valid) begin
            check({tag, "_order0"}, 128'(decode0_inst.pc), 128'(next_out_pc));
            next_out_pc += 32'd4;
         end
         if (decode1_inst.valid) begin
            check({tag, "_order1"}, 128'(decode1_inst.pc), 128'(next_out_pc));
            next_out_pc += 32'd4;
         end
      end
      $display("step %-14s rdy=%0d d0=%0d/%h d1=%0d/%h q=%0d", tag, fetch_ready,
               decode0_inst.valid, decode0_inst.pc, decode1_inst.valid, decode1_inst.pc, sb_q.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      logic [31:0] pc;
      int          k;
      int          guard;

      // Reset with junk on every input.
      drive(1, 32'hDEAD, 1, 32'hBEEF, 1, 1, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_d0", 128'(decode0_inst), 128'(0));
      check("reset_d1", 128'(decode1_inst), 128'(0));
      check("reset_ready", 128'(fetch_ready), 128'(1));
      check("pausereq", 128'(ctrl.pauseReq), 128'(0));

      // Pair 0x100/0x104 appears one cycle after being pushed.
      drive(1, 32'h100, 1, 32'h104, 0, 0, 1);
      step("pair_push", acc);
      drive(0, 32'h0, 0, 32'h0, 0, 0, 1);
      step("pair_out", acc);
      check("pair_d0_pc", 128'(decode0_inst.pc), 128'(32'h100));
      check("pair_d1_pc", 128'(decode1_inst.pc), 128'(32'h104));
      step("pair_empty", acc);

      // Only inst1 valid: compacted into decoder 0 slot.
      drive(0, 32'h1FC, 1, 32'h200, 0, 0, 1);
      step("inst1_push", acc);
      drive(0, 32'h0, 0, 32'h0, 0, 0, 1);
      step("inst1_out", acc);
      check("inst1_d0_pc", 128'(decode0_inst.pc), 128'(32'h200));
      check("inst1_d1_valid", 128'(decode1_inst.valid), 128'(0));

      // Pause for 5 cycles while pushing; ready drops at count 7.
      drive(1, 32'h2F0, 1, 32'h2F4, 0, 0, 1);
      step("pre_pause_push", acc);
      drive(0, 32'h0, 0, 32'h0, 0, 0, 1);
      step("pre_pause_pop", acc);
      drive(1, 32'h300, 0, 32'h0, 1, 0, 1);
      step("pause_single", acc);
      pc = 32'h304;
      for (int i = 0; i < 4; i++) begin
         drive(1, pc, 1, pc + 32'd4, 1, 0, 1);
         step("pause_pair", acc);
         if (acc) pc += 32'd8;
      end
      check("ready_at7", 128'(fetch_ready), 128'(0));
      check("frozen_d0_pc", 128'(decode0_inst.pc), 128'(32'h2F0));
      check("frozen_d1_pc", 128'(decode1_inst.pc), 128'(32'h2F4));
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 10) begin
         drive(1, pc, 1, pc + 32'd4, 0, 0, 1);
         step("release_hold", acc);
         guard++;
      end
      check("held_pair_accepted", 128'(acc), 128'(1));
      for (int i = 0; i < 6; i++) begin
         drive(0, 32'h0, 0, 32'h0, 0, 0, 1);
         step("release_drain", acc);
      end

      // Flush at count 6 with a simultaneous push.
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h400 + 32'(i * 8), 1, 32'h404 + 32'(i * 8), 1, 0, 1);
         step("flush_fill", acc);
      end
      drive(1, 32'h500, 1, 32'h504, 1, 1, 1);
      step("flush", acc);
      check("flush_ready", 128'(fetch_ready), 128'(1));
      drive(0, 32'h0, 0, 32'h0, 0, 0, 1);
      step("post_flush", acc);

      // 20 pairs with random pause, wrapping the pointers several times.
      track_order = 1'b1;
      next_out_pc = 32'h0;
      k = 0;
      guard = 0;
      while ((k < 20 || next_out_pc != 32'hA0) && guard < 400) begin
         if (k < 20) begin
            drive(1, 32'(k * 8), 1, 32'(k * 8 + 4), ($urandom_range(0, 2) == 0), 0, 1);
         end else begin
            drive(0, 32'h0, 0, 32'h0, ($urandom_range(0, 3) == 0), 0, 1);
         end
         step("stream", acc);
         if (acc && k < 20) k++;
         guard++;
      end
      track_order = 1'b0;
      check("stream_end_pc", 128'(next_out_pc), 128'(32'hA0));

      // Reset during flush and pause with a push pending.
      for (int i = 0; i < 2; i++) begin
         drive(1, 32'h600 + 32'(i * 8), 1, 32'h604 + 32'(i * 8), 1, 0, 1);
         step("rst_fill", acc);
      end
      drive(1, 32'h700, 1, 32'h704, 1, 1, 0);
      step("rst_mid", acc);
      drive(0, 32'h0, 0, 32'h0, 0, 0, 1);
      step("rst_after", acc);
      check("rst_after_ready", 128'(fetch_ready), 128'(1));
      check("rst_pausereq", 128'(ctrl.pauseReq), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_decode_queue.md
FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning instruction-queue entries; power of two, minimum 4.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port ctrl_fetch_decode_queue  Ctrl.slave  --  pause in, flush in, pauseReq out.
REQ-005 SHALL have port fetch_inst0  input  InstBundle  first fetched instruction (valid, pc[31:0], inst[31:0], predTaken, predAddr[31:0]).
REQ-006 SHALL have port fetch_inst1  input  InstBundle  second fetched instruction, same fields.
REQ-007 SHALL have port fetch_ready  output  1  queue can accept two instructions this cycle.
REQ-008 SHALL have port decode0_inst  output  InstBundle  instruction for decoder 0, older of the pair.
REQ-009 SHALL have port decode1_inst  output  InstBundle  instruction for decoder 1, younger of the pair.

Function
REQ-010 SHALL implement a circular buffer of DEPTH InstBundle entries, with read pointer, write pointer (log2 DEPTH bits, natural wrap) and count (log2 DEPTH + 1 bits, 0..DEPTH).
REQ-011 SHALL drive fetch_ready = (count <= DEPTH-2), combinationally from registered count only.
REQ-012 SHALL enqueue only when fetch_ready = 1: every input with valid = 1, in program order inst0 then inst1.
REQ-013 SHALL compact on enqueue: only inst1 valid -> written at wr_ptr; both valid -> inst0 at wr_ptr, inst1 at wr_ptr+1; wr_ptr advances by the number written.
REQ-014 SHALL ignore fetch inputs when fetch_ready = 0; fetch holds them.
REQ-015 SHALL register outputs: when pause = 0, on each edge decode0_inst <= entry[rd_ptr] if count >= 1, else all-zero; decode1_inst <= entry[rd_ptr+1] if count >= 2, else all-zero.
REQ-016 SHALL advance rd_ptr and decrement count by min(count, 2) on each edge with pause = 0; this is one-cycle latency from pop to decoder.
REQ-017 SHALL hold decode0_inst, decode1_inst, rd_ptr and pop count unchanged while pause = 1; enqueue continues during pause.
REQ-018 SHALL compute the new count as count + pushed - popped for simultaneous push and pop; there is no overflow, because push requires two free slots before the pop.
REQ-019 SHALL never present decode1 valid with decode0 invalid.
REQ-020 SHALL act on flush (priority over pause and push): pointers and count <= 0, both outputs all-zero, same-cycle fetch inputs discarded.
REQ-021 SHALL tie pauseReq to 0; back-pressure to fetch is only through fetch_ready.
REQ-022 SHALL preserve program order exactly: output pc sequence equals accepted input sequence.

Reset
REQ-023 SHALL, with rst = 0 at an edge, set rd_ptr = wr_ptr = 0, count = 0 and decode0_inst = decode1_inst = all-zero, so that fetch_ready = 1 next cycle.
REQ-024 SHALL let reset override flush, pause and push; reset mid-stream discards all entries.
REQ-025 SHALL NOT reset the storage array; it is gated by count.

Structure
REQ-026 SHALL define the InstBundle struct typedef in the shared defines package, next to UOPBundle.
REQ-027 SHALL place the DEPTH default and the pointer-width localparam in that package.
REQ-028 SHALL be a single module; a separate storage sub-module is not required. An optional iq_ram (DEPTH x InstBundle, two write ports, two read ports) is allowed.

Verification
REQ-029 SHALL cover: reset, then push pc 0x100/0x104 both valid -> next cycle decode0 pc 0x100, decode1 pc 0x104, count 0.
REQ-030 SHALL cover: only inst1 valid with pc 0x200 -> appears on decode0 with decode1 invalid.
REQ-031 SHALL cover: pause held 5 cycles while pushing pairs -> fetch_ready drops at count 7 (DEPTH 8), outputs frozen, no entry lost after release.
REQ-032 SHALL cover: 20 pairs streamed with random pause, exercising pointer wrap -> pc order contiguous 0x0..0x9C.
REQ-033 SHALL cover: flush asserted with count 6 and a push the same cycle -> next cycle outputs invalid, count 0, fetch_ready 1.
REQ-034 SHALL cover: rst = 0 during flush and pause -> state as REQ-023.
